fb_mem_arbiter: RTL and testbench
=================================

# fb_mem_arbiter

Two-master Avalon-MM arbiter sharing the single frame-buffer memory slave between the VGA pixel fetcher (master 0, latency-critical) and the HPS lightweight-bridge drawing path (master 1). It sits between the two masters and the on-chip/SDRAM frame-buffer slave inside the Qsys system that drives the `vga_*` outputs. It supports pipelined reads with variable latency and routes each `readdatavalid` back to the master that issued the read.

## Interface
Parameters:
- `ADDR_W`, 32: address width, all ports.
- `DATA_W`, 32: data width; `DATA_W/8` byteenable bits.
- `MAX_PEND`, 8: maximum outstanding reads; power of two, 2..64.
- `STARVE_LIMIT`, 16: consecutive denied cycles before master 1 is forced a grant. Used only with the guard macro.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `m0_address`/`m1_address`  in  ADDR_W  master command address.
- `m0_read`/`m1_read`, `m0_write`/`m1_write`  in  1  command strobes; never both high on one master.
- `m0_writedata`/`m1_writedata`  in  DATA_W  write data.
- `m0_byteenable`/`m1_byteenable`  in  DATA_W/8  byte enables.
- `m0_waitrequest`/`m1_waitrequest`  out  1  command not accepted this cycle.
- `m0_readdata`/`m1_readdata`  out  DATA_W  read data, copied from `s_readdata`.
- `m0_readdatavalid`/`m1_readdatavalid`  out  1  read data valid for this master.
- `s_address`  out  ADDR_W; `s_read`, `s_write`  out  1; `s_writedata`  out  DATA_W; `s_byteenable`  out  DATA_W/8.
- `s_waitrequest`  in  1; `s_readdata`  in  DATA_W; `s_readdatavalid`  in  1.
- `err_rdv`  out  1  sticky flag: `s_readdatavalid` arrived with no read pending.

## Operation
- Request: `mX_req = mX_read | mX_write`. Grant `g` selects which master's command fields drive `s_*`. When neither master has a granted request, `s_read`/`s_write` are 0.
- Lock register: set when the granted command is on the slave and `s_waitrequest`=1; cleared on acceptance (`s_waitrequest`=0). While the lock is set, `g` is frozen. The command may not change mid-stall.
- Unlocked selection: master 0 has priority. Master 1 is granted only when `m0_req`=0, or when the starvation guard fires.
- Accept: `acc = (s_read|s_write) & !s_waitrequest`. `mg_waitrequest = !acc`. The non-granted master sees waitrequest=1.
- Tag FIFO: `MAX_PEND` entries, 1 bit each (owner id).
  - Push `g` on an accepted read.
  - Pop on `s_readdatavalid`.
  - `mX_readdatavalid = s_readdatavalid & head==X & !empty`.
  - Push and pop in the same cycle: count unchanged, full or empty allowed.
- FIFO full: a granted read is blocked. `s_read` is forced to 0 and the master sees waitrequest=1. The lock is not set. Writes still proceed; a master-1 write may pass a blocked master-0 read.
- `s_readdatavalid` with the FIFO empty (and no same-cycle push): no `mX_readdatavalid`; `err_rdv` set until reset.
- Writes produce no response and no tag.

## Timing
- Command path is combinational, zero added latency: accept happens in the same cycle as `s_waitrequest`=0.
- Response path is combinational: `mX_readdatavalid` is asserted in the same cycle as `s_readdatavalid`.
- Registered state: lock, `g` when locked, FIFO pointers/count, starvation counter, `err_rdv`.
- Reset values:
  - Lock=0, FIFO empty, counter=0, `err_rdv`=0.
  - `s_read`=`s_write`=0.
  - `m0_waitrequest`=`m1_waitrequest`=1.
  - `m0_readdatavalid`=`m1_readdatavalid`=0.
- Reset mid-operation flushes pending tags. The slave shares `reset` and must also discard in-flight reads.

## Configuration
- `FB_ARB_STARVE_GUARD_EN` defined:
  - A counter increments each cycle that `m1_req`=1 and master 1 is not accepted; it clears on master-1 accept or when `m1_req`=0.
  - When the counter reaches `STARVE_LIMIT` and the arbiter is unlocked, master 1 is granted for exactly one accepted command, overriding master 0. The counter then clears.
- Undefined: strict master-0 priority, no counter. Master 1 can starve indefinitely.

## Test plan
- Single read per master, slave latency 3: m0 read addr 0x100 returns 0xAAAA0001 → only `m0_readdatavalid` pulses, 3 cycles after accept. Same for m1 with 0xBBBB0002 → only `m1_readdatavalid`.
- Simultaneous m0 read and m1 write, `s_waitrequest`=1 for 2 cycles:
  - m0 is held on the slave for 3 cycles with the address stable.
  - The m1 write is accepted the cycle after m0 accepts.
  - `m1_waitrequest`=1 throughout.
- 8 back-to-back reads, alternating masters, slave latency 10 (`MAX_PEND`=8): ninth read is blocked with `s_read`=0. Returns route in order m0,m1,m0,…. A push and pop in the same cycle keeps count=8.
- With the guard defined and `STARVE_LIMIT`=16, m0 requests continuously and m1 holds a write: m1 is accepted on its 17th request cycle, then m0 resumes. Without the guard, m1 is never accepted.
- `s_readdatavalid` injected with the FIFO empty → no `mX_readdatavalid`, `err_rdv`=1 and stays 1. Reset asserted for 1 cycle → all outputs return to their reset values.

Source files
------------

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter
//   Two-master Avalon-MM arbiter for the shared frame-buffer slave.
//   Master 0 is the VGA pixel fetcher (priority), master 1 is the HPS
//   drawing path. Pipelined reads with variable latency are supported; a
//   1-bit owner tag per outstanding read routes each readdatavalid back to
//   the master that issued it.
//
//   Optional feature macro: FB_ARB_STARVE_GUARD_EN
//     defined   : master 1 is forced one grant after STARVE_LIMIT
//                 consecutive denied request cycles.
//     undefined : strict master-0 priority.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   m0_* / m1_*                     master command/response ports
//   s_*                             slave command/response port
//   err_rdv                         sticky: readdatavalid with no read pending
module fb_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_PEND     = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  output logic                err_rdv
);

  localparam int PW = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CW = PW + 1;

  logic w_m0_req, w_m1_req;
  logic w_g;
  logic w_force;
  logic w_sel_read, w_sel_write;
  logic w_rd_block;
  logic w_acc, w_push, w_pop;
  logic w_empty, w_full, w_head;

  logic                r_lock;
  logic                r_lock_g;
  logic                r_err;
  logic [MAX_PEND-1:0] r_tag;
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;

  assign w_m0_req = m0_read | m0_write;
  assign w_m1_req = m1_read | m1_write;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(MAX_PEND));
  assign w_head  = r_tag[r_rd_ptr];

  // A full tag FIFO blocks reads, except when a response pops an entry in
  // the same cycle: push and pop together keep the count at MAX_PEND.
  assign w_rd_block = w_full & ~s_readdatavalid;

`ifdef FB_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;

  assign w_force = w_m1_req & (r_starve == SW'(STARVE_LIMIT));

  // Saturates at the limit; a locked master-0 transfer simply defers the
  // forced grant until the arbiter unlocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (~w_m1_req | (w_acc & w_g)) begin
      r_starve <= '0;
    end else if (~w_force) begin
      r_starve <= r_starve + SW'(1);
    end
  end
`else
  assign w_force = 1'b0;
`endif

  // Grant: frozen while a stalled command is on the slave. Unlocked, a
  // master-0 read that the full FIFO would block does not hold the grant,
  // so a master-1 write can pass it.
  always_comb begin
    if (r_lock) begin
      w_g = r_lock_g;
    end else if (w_force) begin
      w_g = 1'b1;
    end else if (m0_write | (m0_read & ~w_rd_block)) begin
      w_g = 1'b0;
    end else begin
      w_g = w_m1_req;
    end
  end

  assign w_sel_read  = w_g ? m1_read  : m0_read;
  assign w_sel_write = w_g ? m1_write : m0_write;

  assign s_read       = ~reset & w_sel_read & ~w_rd_block;
  assign s_write      = ~reset & w_sel_write;
  assign s_address    = w_g ? m1_address    : m0_address;
  assign s_writedata  = w_g ? m1_writedata  : m0_writedata;
  assign s_byteenable = w_g ? m1_byteenable : m0_byteenable;

  assign w_acc  = (s_read | s_write) & ~s_waitrequest;
  assign w_push = w_acc & s_read;
  // A response with an empty FIFO only pops if a tag is pushed alongside,
  // keeping the count unchanged in that cycle.
  assign w_pop  = s_readdatavalid & (~w_empty | w_push);

  assign m0_waitrequest = ~(w_acc & ~w_g);
  assign m1_waitrequest = ~(w_acc &  w_g);

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = ~reset & s_readdatavalid & ~w_empty & ~w_head;
  assign m1_readdatavalid = ~reset & s_readdatavalid & ~w_empty &  w_head;

  assign err_rdv = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock   <= 1'b0;
      r_lock_g <= 1'b0;
    end else begin
      r_lock   <= (s_read | s_write) & s_waitrequest;
      r_lock_g <= w_g;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_tag[r_wr_ptr] <= w_g;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push & ~w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (~w_push & w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (s_readdatavalid & w_empty & ~w_push) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
module tb_fb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] m0_address = '0, m1_address = '0;
  logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
  logic [3:0]    m0_byteenable = '0, m1_byteenable = '0;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] s_address;
  logic          s_read, s_write;
  logic [DW-1:0] s_writedata;
  logic [3:0]    s_byteenable;
  logic          s_waitrequest = 1'b0;
  logic [DW-1:0] s_readdata = '0;
  logic          s_readdatavalid = 1'b0;
  logic          err_rdv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PEND(8), .STARVE_LIMIT(16)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .err_rdv(err_rdv)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hAAAA_0001;
      32'h0000_0200: return 32'hBBBB_0002;
      default:       return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  // Slave model: fixed latency `lat` from accept to readdatavalid; `inj`
  // forces a spurious response in the current cycle.
  typedef struct {int due; logic [31:0] data;} rsp_t;
  rsp_t q[$];
  int   cyc = 0;
  int   lat = 3;
  logic inj = 1'b0;

  initial forever begin
    rsp_t r;
    @(posedge clk);
    cyc++;
    if (reset) begin
      q.delete();
    end else if (s_read && !s_waitrequest) begin
      r.due  = cyc - 1 + lat;
      r.data = mem_data(s_address);
      q.push_back(r);
    end
    #2;
    if (inj) begin
      s_readdatavalid = 1'b1;
      s_readdata      = 32'hDEAD_BEEF;
    end else if (q.size() > 0 && q[0].due == cyc) begin
      s_readdatavalid = 1'b1;
      s_readdata      = q[0].data;
      q.delete(0);
    end else begin
      s_readdatavalid = 1'b0;
      s_readdata      = '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
  endtask

  function automatic int ret_idx(input int c);
    if (c >= 10 && c <= 17) return c - 10;
    if (c >= 20 && c <= 27) return c - 12;
    if (c == 30) return 16;
    return -1;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  j;
    int  r;
    bit  exp_acc;
    bit  exp_m1;
    bit  guard;
    bit  m1_done;

`ifdef FB_ARB_STARVE_GUARD_EN
    guard = 1'b1;
`else
    guard = 1'b0;
`endif

    // Reset state, with a request pending to prove outputs are held quiet.
    m0_read = 1'b1; m0_address = 32'h100;
    #3;
    chk("rst_s_read", s_read, 0);
    chk("rst_s_write", s_write, 0);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_m0_rdv", m0_readdatavalid, 0);
    chk("rst_m1_rdv", m1_readdatavalid, 0);
    tick();
    tick();
    reset = 1'b0; idle();
    tick();

    // Single read per master, latency 3.
    lat = 3;
    m0_read = 1'b1; m0_address = 32'h100;
    #2;
    chk("rd0_s_read", s_read, 1);
    chk("rd0_s_addr", s_address, 32'h100);
    chk("rd0_m0_wait", m0_waitrequest, 0);
    chk("rd0_m1_wait", m1_waitrequest, 1);
    tick(); idle();
    for (int i = 1; i <= 3; i++) begin
      #2;
      chk("rd0_m0_rdv", m0_readdatavalid, (i == 3));
      chk("rd0_m1_rdv", m1_readdatavalid, 0);
      if (i == 3) chk("rd0_data", m0_readdata, 32'hAAAA_0001);
      tick();
    end
    m1_read = 1'b1; m1_address = 32'h200;
    #2;
    chk("rd1_s_addr", s_address, 32'h200);
    chk("rd1_m1_wait", m1_waitrequest, 0);
    tick(); idle();
    for (int i = 1; i <= 3; i++) begin
      #2;
      chk("rd1_m1_rdv", m1_readdatavalid, (i == 3));
      chk("rd1_m0_rdv", m0_readdatavalid, 0);
      if (i == 3) chk("rd1_data", m1_readdata, 32'hBBBB_0002);
      tick();
    end

    // m0 read stalled 2 cycles against a concurrent m1 write.
    m0_read = 1'b1; m0_address = 32'h300;
    m1_write = 1'b1; m1_address = 32'h400; m1_writedata = 32'h1234_5678; m1_byteenable = 4'hF;
    for (int i = 0; i < 3; i++) begin
      s_waitrequest = (i < 2);
      #2;
      chk("stall_s_read", s_read, 1);
      chk("stall_s_write", s_write, 0);
      chk("stall_s_addr", s_address, 32'h300);
      chk("stall_m0_wait", m0_waitrequest, (i < 2));
      chk("stall_m1_wait", m1_waitrequest, 1);
      tick();
    end
    m0_read = 1'b0;
    #2;
    chk("wr1_s_write", s_write, 1);
    chk("wr1_s_addr", s_address, 32'h400);
    chk("wr1_wdata", s_writedata, 32'h1234_5678);
    chk("wr1_be", s_byteenable, 4'hF);
    chk("wr1_m1_wait", m1_waitrequest, 0);
    tick(); idle();
    #2; chk("stall_rdv_early", m0_readdatavalid, 0);
    tick();
    #2;
    chk("stall_rdv", m0_readdatavalid, 1);
    chk("stall_data", m0_readdata, 32'hC0DE_0300);
    tick();

    // Lock holds a stalled m1 write even when m0 arrives.
    m1_write = 1'b1; m1_address = 32'h600; s_waitrequest = 1'b1;
    #2; chk("lock_addr0", s_address, 32'h600);
    tick();
    m0_read = 1'b1; m0_address = 32'h700;
    #2;
    chk("lock_addr1", s_address, 32'h600);
    chk("lock_s_read", s_read, 0);
    chk("lock_m0_wait", m0_waitrequest, 1);
    tick();
    s_waitrequest = 1'b0;
    #2;
    chk("lock_addr2", s_address, 32'h600);
    chk("lock_m1_wait", m1_waitrequest, 0);
    chk("lock_m0_wait2", m0_waitrequest, 1);
    tick();
    m1_write = 1'b0;
    #2;
    chk("lock_m0_go", m0_waitrequest, 0);
    chk("lock_m0_addr", s_address, 32'h700);
    tick(); idle();
    for (int i = 0; i < 4; i++) tick();

    // Fill the tag FIFO with latency 10, alternating masters.
    lat = 10; j = 0;
    for (int c = 0; c < 32; c++) begin
      idle();
      if (j < 17) begin
        if (j % 2 == 0) begin m0_read = 1'b1; m0_address = 32'h1000 + 32'(j * 4); end
        else begin m1_read = 1'b1; m1_address = 32'h1000 + 32'(j * 4); end
      end
      exp_acc = (c < 8) || (c >= 10 && c <= 17) || (c == 20);
      #2;
      if (j < 17) begin
        chk("fill_s_read", s_read, exp_acc);
        chk("fill_wait", (j % 2 == 0) ? m0_waitrequest : m1_waitrequest, !exp_acc);
      end
      r = ret_idx(c);
      chk("fill_m0_rdv", m0_readdatavalid, (r >= 0) && (r % 2 == 0));
      chk("fill_m1_rdv", m1_readdatavalid, (r >= 0) && (r % 2 == 1));
      if (r >= 0) chk("fill_data", s_readdata, {16'hC0DE, 16'(32'h1000 + 32'(r * 4))});
      tick();
      if (exp_acc && j < 17) j++;
    end
    idle();

    // Starvation: m0 writes continuously, m1 holds a write.
    m0_write = 1'b1; m0_address = 32'h500; m0_writedata = 32'h1;
    m1_write = 1'b1; m1_address = 32'h600;
    m1_done = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      exp_m1 = guard && (n == 17);
      #2;
      if (!m1_done) chk("starve_m1_wait", m1_waitrequest, !exp_m1);
      chk("starve_m0_wait", m0_waitrequest, exp_m1);
      tick();
      if (exp_m1) begin m1_write = 1'b0; m1_done = 1'b1; end
    end
    idle();
    tick();

    // Reset mid-flight flushes the pending tag; a later stray response
    // is then unexpected.
    lat = 10;
    m0_read = 1'b1; m0_address = 32'h100;
    #2; chk("flush_acc", m0_waitrequest, 0);
    tick(); idle();
    tick();
    reset = 1'b1;
    #2; chk("flush_rst_sread", s_read, 0);
    tick();
    reset = 1'b0;
    inj = 1'b1;
    #2;
    chk("inj_m0_rdv", m0_readdatavalid, 0);
    chk("inj_m1_rdv", m1_readdatavalid, 0);
    chk("inj_err_pre", err_rdv, 0);
    tick();
    inj = 1'b0;
    #2; chk("inj_err_set", err_rdv, 1);
    for (int i = 0; i < 12; i++) tick();
    #2;
    chk("inj_err_sticky", err_rdv, 1);
    chk("inj_late_m0_rdv", m0_readdatavalid, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    chk("fin_err", err_rdv, 0);
    chk("fin_s_read", s_read, 0);
    chk("fin_s_write", s_write, 0);
    chk("fin_m0_wait", m0_waitrequest, 1);
    chk("fin_m1_wait", m1_waitrequest, 1);
    chk("fin_m0_rdv", m0_readdatavalid, 0);
    chk("fin_m1_rdv", m1_readdatavalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
